// File: rtl/pulse_stretcher_if.sv
// Pulse-in / stretched-level-out bundle for pulse_stretcher.
interface pulse_stretcher_if;
  logic PulseIn;
  logic SignalOut;
  logic Busy;
  logic Dropped;

  // Pulse source side
  modport master (
    output PulseIn,
    input  SignalOut,
    input  Busy,
    input  Dropped
  );

  // Stretcher side
  modport slave (
    input  PulseIn,
    output SignalOut,
    output Busy,
    output Dropped
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into a level with a minimum high time
// (HOLD_CYCLES) and a minimum low time (GAP_CYCLES). One pulse may be queued
// while busy; any further pulse is flagged on Dropped for one cycle.
module pulse_stretcher #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned RETRIGGER   = 0,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  pulse_stretcher_if.slave ps
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               RETRIG_EN = (RETRIGGER != 0);

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             pend_q,      pend_d;
  logic             sig_out_q,   sig_out_d;
  logic             busy_q,      busy_d;
  logic             dropped_q,   dropped_d;

  logic pulse_c;
  logic cnt_zero_c;

  assign pulse_c    = ps.PulseIn;
  assign cnt_zero_c = (cnt_q == '0);

  // Next state, counter, pending flag and drop decision
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    dropped_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pulse_c) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end

      HOLD: begin
        if (RETRIG_EN && pulse_c) begin
          // Restart the high period, even on its last cycle
          cnt_d = HOLD_LOAD;
        end else begin
          if (pulse_c) begin
            if (!pend_q) begin
              pend_d = 1'b1;
            end else begin
              dropped_d = 1'b1;
            end
          end
          if (cnt_zero_c) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      GAP: begin
        if (cnt_zero_c) begin
          if (pend_q || pulse_c) begin
            // Serve one pulse; a simultaneous second one is discarded
            state_d   = HOLD;
            cnt_d     = HOLD_LOAD;
            pend_d    = 1'b0;
            dropped_d = pend_q && pulse_c;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (pulse_c) begin
            if (!pend_q) begin
              pend_d = 1'b1;
            end else begin
              dropped_d = 1'b1;
            end
          end
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register with it
  always_comb begin
    sig_out_d = (state_d == HOLD);
    busy_d    = (state_d != IDLE);
  end

  // State and output registers; reset clears everything without a clock
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      sig_out_q <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      sig_out_q <= sig_out_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  assign ps.SignalOut = sig_out_q;
  assign ps.Busy      = busy_q;
  assign ps.Dropped   = dropped_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: queueing instance (if0) and
// retriggering instance (if1), both with HOLD=8, GAP=2.
module tb_pulse_stretcher;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pulse_stretcher_if if0();
  pulse_stretcher_if if1();

  pulse_stretcher #(
    .HOLD_CYCLES(8), .GAP_CYCLES(2), .RETRIGGER(0), .CNT_W(4)
  ) dut0 (
    .CLK   (clk),
    .RESET (rst_n),
    .ps    (if0)
  );

  pulse_stretcher #(
    .HOLD_CYCLES(8), .GAP_CYCLES(2), .RETRIGGER(1), .CNT_W(4)
  ) dut1 (
    .CLK   (clk),
    .RESET (rst_n),
    .ps    (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive inputs just after the rising edge, return at the falling edge
  task automatic step(input logic p0, input logic p1);
    @(posedge clk);
    #1;
    if0.PulseIn = p0;
    if1.PulseIn = p1;
    @(negedge clk);
  endtask

  // Reset both instances; cycle 0 of the caller is the first cycle after release
  task automatic do_reset();
    if0.PulseIn = 1'b0;
    if1.PulseIn = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic es, eb;
    rst_n = 1'b0;
    if0.PulseIn = 1'b0;
    if1.PulseIn = 1'b0;
    #2;
    checks++;
    if (if0.SignalOut !== 1'b0 || if0.Busy !== 1'b0 || if0.Dropped !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: got sig=%b busy=%b drop=%b expected 000",
               if0.SignalOut, if0.Busy, if0.Dropped);
    end
    do_reset();
    // Start a high period at c=2 and queue a second pulse at c=5
    for (int c = 0; c <= 7; c++) begin
      step(c == 2 || c == 5, 1'b0);
    end
    checks++;
    if (if0.SignalOut !== 1'b1 || if0.Busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_hold: got sig=%b busy=%b expected 11",
               if0.SignalOut, if0.Busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if0.SignalOut !== 1'b0 || if0.Busy !== 1'b0 || if0.Dropped !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got sig=%b busy=%b drop=%b expected 000",
               if0.SignalOut, if0.Busy, if0.Dropped);
    end
    // Pulses while reset is held must be ignored
    if0.PulseIn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (if0.SignalOut !== 1'b0 || if0.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignore_pulse: got sig=%b busy=%b expected 00",
               if0.SignalOut, if0.Busy);
    end
    if0.PulseIn = 1'b0;
    rst_n = 1'b1;
    // Fresh pulse in the first cycle after release; queued pulse must be gone
    for (int c = 0; c <= 14; c++) begin
      step(c == 0, 1'b0);
      es = (c >= 1 && c <= 8);
      eb = (c >= 1 && c <= 10);
      checks++;
      if (if0.SignalOut !== es || if0.Busy !== eb || if0.Dropped !== 1'b0) begin
        errors++;
        $display("FAIL reset_after c=%0d: got sig=%b busy=%b drop=%b expected %b%b0",
                 c, if0.SignalOut, if0.Busy, if0.Dropped, es, eb);
      end
    end
  endtask

  task automatic test_single();
    logic es, eb;
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      step(c == 10, 1'b0);
      es = (c >= 11 && c <= 18);
      eb = (c >= 11 && c <= 20);
      checks++;
      if (if0.SignalOut !== es || if0.Busy !== eb || if0.Dropped !== 1'b0) begin
        errors++;
        $display("FAIL single c=%0d: got sig=%b busy=%b drop=%b expected %b%b0",
                 c, if0.SignalOut, if0.Busy, if0.Dropped, es, eb);
      end
    end
  endtask

  task automatic test_queue();
    logic es, eb, ed;
    do_reset();
    for (int c = 0; c <= 33; c++) begin
      step(c == 10 || c == 13 || c == 15, 1'b0);
      es = (c >= 11 && c <= 18) || (c >= 21 && c <= 28);
      eb = (c >= 11 && c <= 30);
      ed = (c == 16);
      checks++;
      if (if0.SignalOut !== es || if0.Busy !== eb || if0.Dropped !== ed) begin
        errors++;
        $display("FAIL queue c=%0d: got sig=%b busy=%b drop=%b expected %b%b%b",
                 c, if0.SignalOut, if0.Busy, if0.Dropped, es, eb, ed);
      end
    end
  endtask

  task automatic test_retrigger();
    logic es, eb;
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      step(1'b0, c == 10 || c == 18);
      es = (c >= 11 && c <= 26);
      eb = (c >= 11 && c <= 28);
      checks++;
      if (if1.SignalOut !== es || if1.Busy !== eb || if1.Dropped !== 1'b0) begin
        errors++;
        $display("FAIL retrigger c=%0d: got sig=%b busy=%b drop=%b expected %b%b0",
                 c, if1.SignalOut, if1.Busy, if1.Dropped, es, eb);
      end
    end
  endtask

  task automatic test_gap_collision();
    logic es, eb, ed;
    int   drops;
    drops = 0;
    do_reset();
    // c=11 queues; c=20 is the last GAP cycle with the queue still full
    for (int c = 0; c <= 33; c++) begin
      step(c == 10 || c == 11 || c == 20, 1'b0);
      es = (c >= 11 && c <= 18) || (c >= 21 && c <= 28);
      eb = (c >= 11 && c <= 30);
      ed = (c == 21);
      if (if0.Dropped === 1'b1) drops++;
      checks++;
      if (if0.SignalOut !== es || if0.Busy !== eb || if0.Dropped !== ed) begin
        errors++;
        $display("FAIL gap_collision c=%0d: got sig=%b busy=%b drop=%b expected %b%b%b",
                 c, if0.SignalOut, if0.Busy, if0.Dropped, es, eb, ed);
      end
    end
    checks++;
    if (drops !== 1) begin
      errors++;
      $display("FAIL gap_collision_drops: got %0d expected 1", drops);
    end
  endtask

  task automatic test_back_to_back();
    logic es, eb, ed, prev_sig;
    int   drops, served;
    drops    = 0;
    served   = 0;
    prev_sig = 1'b0;
    do_reset();
    // PulseIn high for cycles 10..29 (20 pulses)
    for (int c = 0; c <= 45; c++) begin
      step(c >= 10 && c <= 29, 1'b0);
      es = (c >= 11 && c <= 18) || (c >= 21 && c <= 28) || (c >= 31 && c <= 38);
      eb = (c >= 11 && c <= 40);
      ed = (c >= 13 && c <= 21) || (c >= 23 && c <= 30);
      if (if0.Dropped === 1'b1) drops++;
      if (if0.SignalOut === 1'b1 && prev_sig === 1'b0) served++;
      prev_sig = if0.SignalOut;
      checks++;
      if (if0.SignalOut !== es || if0.Busy !== eb || if0.Dropped !== ed) begin
        errors++;
        $display("FAIL back_to_back c=%0d: got sig=%b busy=%b drop=%b expected %b%b%b",
                 c, if0.SignalOut, if0.Busy, if0.Dropped, es, eb, ed);
      end
    end
    checks++;
    if (served !== 3) begin
      errors++;
      $display("FAIL back_to_back_served: got %0d expected 3", served);
    end
    checks++;
    if (drops !== 17) begin
      errors++;
      $display("FAIL back_to_back_drops: got %0d expected 17", drops);
    end
    checks++;
    if (drops + served !== 20) begin
      errors++;
      $display("FAIL back_to_back_total: got %0d expected 20", drops + served);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    if0.PulseIn = 1'b0;
    if1.PulseIn = 1'b0;
    test_reset();
    test_single();
    test_queue();
    test_retrigger();
    test_gap_collision();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle strobes, such as the output of the one-shot debouncer, back into a level signal with a guaranteed minimum high time and a guaranteed minimum low time. Typical loads are board LEDs, external enables, and slow-domain consumers that cannot see a 1-cycle pulse. It sits on the output side of a control path, clocked by the same system clock as the pulse source. At most one pulse can be queued while the output is busy; further pulses are reported as dropped.

## Interface
- HOLD_CYCLES, 8: cycles SignalOut stays high per accepted pulse; must be ≥ 1.
- GAP_CYCLES, 2: cycles SignalOut is forced low after each high period; must be ≥ 1.
- RETRIGGER, 0: 1 = a pulse during HOLD restarts the high period; 0 = a pulse during HOLD is queued.
- CNT_W, 4: counter width; 2^CNT_W must be > max(HOLD_CYCLES, GAP_CYCLES) − 1.

Ports (name, direction, width, meaning):
- CLK, in, 1: system clock, rising edge.
- RESET, in, 1: asynchronous, active-low reset.
- PulseIn, in, 1: strobe, already synchronous to CLK. Every high cycle counts as one pulse.
- SignalOut, out, 1: stretched level, driven from a register.
- Busy, out, 1: high when the state is not IDLE; registered.
- Dropped, out, 1: 1-cycle flag marking a discarded pulse; registered.

## Operation
- State machine states: IDLE, HOLD, GAP. Internal registers: down-counter cnt[CNT_W-1:0] and a 1-bit flag pend.
- IDLE: SignalOut=0. If PulseIn=1, go to HOLD and load cnt=HOLD_CYCLES−1.
- HOLD: SignalOut=1.
  - RETRIGGER=1 and PulseIn=1: load cnt=HOLD_CYCLES−1 and stay in HOLD. This applies even when cnt==0.
  - RETRIGGER=0 and PulseIn=1: set pend if it is clear. If pend is already set, pulse Dropped.
  - No reload and cnt==0: go to GAP and load cnt=GAP_CYCLES−1.
  - Otherwise decrement cnt.
- GAP: SignalOut=0.
  - PulseIn=1 sets pend if it is clear; otherwise pulse Dropped.
  - At cnt==0: if pend=1 or PulseIn=1, go to HOLD, load cnt=HOLD_CYCLES−1, and clear pend. Otherwise go to IDLE.
  - If pend=1 and PulseIn=1 both hold at cnt==0, one pulse is served and the other is Dropped.
- Pulses are never merged silently. Every input high cycle results in exactly one of: starting a high period, a reload, setting pend, or a Dropped pulse.
- Counter arithmetic is unsigned and never wraps, because decrement happens only when cnt>0.

## Timing
- Reset values: SignalOut=0, Busy=0, Dropped=0, pend=0, cnt=0, state=IDLE.
- Reset assertion takes effect immediately, with no clock needed. This applies in any state and discards any pending pulse.
- PulseIn is ignored while RESET=0. A pulse in the first cycle after deassertion is accepted normally.
- Let PulseIn be high in cycle t while the block is IDLE. Then:
  - SignalOut is high in cycles t+1 … t+HOLD_CYCLES.
  - SignalOut is low in cycles t+HOLD_CYCLES+1 … t+HOLD_CYCLES+GAP_CYCLES.
  - Busy is high in cycles t+1 … t+HOLD_CYCLES+GAP_CYCLES.
- A pending pulse starts its high period at t+HOLD_CYCLES+GAP_CYCLES+1. The minimum low gap between high periods is always exactly GAP_CYCLES.
- Dropped goes high in the cycle after the discarded PulseIn cycle, for 1 cycle per dropped pulse.
- Latency from PulseIn to SignalOut rising edge is 1 cycle from IDLE, with no combinational path from input to output.

## Test plan
- Reset behaviour: apply RESET=0 mid-HOLD with pend=1 → SignalOut, Busy and Dropped all go to 0 immediately. After release, a pulse gives SignalOut high for 8 cycles starting 1 cycle later.
- Single pulse (defaults): PulseIn high at cycle 10 → SignalOut high in cycles 11–18, low in 19–20; Busy high in 11–20; Dropped stays 0.
- Queueing (RETRIGGER=0): pulses at cycles 10, 13 and 15 → first high period 11–18, gap 19–20, second high period 21–28; Dropped high at cycle 16 only.
- Retrigger (RETRIGGER=1): pulses at cycles 10 and 18 → SignalOut continuously high in 11–26, gap 27–28; Dropped stays 0.
- GAP-edge collision: pend set and PulseIn high on the final GAP cycle → exactly one new HOLD starts next cycle; Dropped asserted once.
- Back-to-back: PulseIn held high for 20 cycles with RETRIGGER=0 → check periodic 8-high/2-low output and that the count of Dropped pulses plus served pulses equals 20.
